// File: rtl/mpeg_stream_feeder.sv
// Compressed-byte feeder for the mpeg2video decoder: buffers source bytes,
// runs the decoder register init sequence after reset, and services flushes.
module mpeg_stream_feeder #(
    parameter int unsigned DEPTH      = 16,
    parameter logic [4:0]  INIT_ADDR0 = 5'd0,
    parameter logic [31:0] INIT_DATA0 = 32'h0,
    parameter logic [4:0]  INIT_ADDR1 = 5'd1,
    parameter logic [31:0] INIT_DATA1 = 32'h0,
    parameter logic [4:0]  FLUSH_ADDR = 5'd2,
    parameter logic [31:0] FLUSH_DATA = 32'h1
) (
    input  logic                     sys_clk,
    input  logic                     RESET_N,
    input  logic [7:0]               src_data,
    input  logic                     src_valid,
    output logic                     src_ready,
    input  logic                     flush,
    input  logic                     busy,
    output logic [7:0]               stream_data,
    output logic                     stream_valid,
    output logic [4:0]               reg_addr,
    output logic [31:0]              reg_dta_in,
    output logic                     reg_wr_en,
    output logic                     init_done,
    output logic [$clog2(DEPTH):0]   level,
    output logic [31:0]              byte_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [2:0] {INIT0, INIT1, STREAM, FLUSH, FLUSHWR} state_t;

    state_t        state_q, state_d;
    logic [1:0]    rst_sync;
    logic          en;
    logic          flush_pend_q, flush_pend_d;
    logic          do_pop;
    logic          push;
    logic          wr_d;
    logic [4:0]    addr_d;
    logic [31:0]   data_d;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    mem [DEPTH];

    assign en        = rst_sync[1];
    assign src_ready = en && (level < LW'(DEPTH)) && (state_q != FLUSH) && (state_q != FLUSHWR);
    assign push      = src_valid && src_ready;

    // Two-flop synchroniser so the FSM leaves reset cleanly after deassertion
    always_ff @(posedge sys_clk or negedge RESET_N) begin
        if (!RESET_N) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    // State, pending-flush and init flag registers
    always_ff @(posedge sys_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= INIT0;
            flush_pend_q <= 1'b0;
            init_done    <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            if (en && state_q == INIT1) init_done <= 1'b1;
        end
    end

    // Next-state, pop decision and register-bus values
    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        do_pop       = 1'b0;
        wr_d         = 1'b0;
        addr_d       = reg_addr;
        data_d       = reg_dta_in;
        if (en) begin
            case (state_q)
                INIT0: begin
                    wr_d    = 1'b1;
                    addr_d  = INIT_ADDR0;
                    data_d  = INIT_DATA0;
                    state_d = INIT1;
                    if (flush) flush_pend_d = 1'b1;
                end
                INIT1: begin
                    wr_d    = 1'b1;
                    addr_d  = INIT_ADDR1;
                    data_d  = INIT_DATA1;
                    state_d = STREAM;
                    if (flush) flush_pend_d = 1'b1;
                end
                STREAM: begin
                    if (flush || flush_pend_q) begin
                        state_d      = FLUSH;
                        flush_pend_d = 1'b0;
                    end else if (level != '0 && !busy) begin
                        do_pop = 1'b1;
                    end
                end
                FLUSH: state_d = FLUSHWR;
                FLUSHWR: begin
                    wr_d    = 1'b1;
                    addr_d  = FLUSH_ADDR;
                    data_d  = FLUSH_DATA;
                    state_d = STREAM;
                end
                default: state_d = INIT0;
            endcase
        end
    end

    // Registered decoder register-bus outputs
    always_ff @(posedge sys_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            reg_wr_en  <= 1'b0;
            reg_addr   <= 5'd0;
            reg_dta_in <= 32'd0;
        end else begin
            reg_wr_en  <= wr_d;
            reg_addr   <= addr_d;
            reg_dta_in <= data_d;
        end
    end

    // FIFO storage; contents are don't-care once pointers are reset
    always_ff @(posedge sys_clk) begin
        if (push) mem[wr_ptr] <= src_data;
    end

    // FIFO pointers, occupancy, output byte and issued-byte counter
    always_ff @(posedge sys_clk or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            byte_count   <= 32'd0;
            stream_valid <= 1'b0;
            stream_data  <= 8'd0;
        end else if (state_q == FLUSH) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            byte_count   <= 32'd0;
            stream_valid <= 1'b0;
        end else begin
            stream_valid <= do_pop;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) begin
                rd_ptr      <= rd_ptr + AW'(1);
                stream_data <= mem[rd_ptr];
                byte_count  <= byte_count + 32'd1;
            end
            case ({push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: tb/tb_mpeg_stream_feeder.sv
// Scoreboard bench for mpeg_stream_feeder: random byte traffic against a queue model.
module tb_mpeg_stream_feeder;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
    localparam logic [4:0]  A0 = 5'd3;
    localparam logic [31:0] D0 = 32'hA5;
    localparam logic [4:0]  A1 = 5'd4;
    localparam logic [31:0] D1 = 32'h5A;
    localparam logic [4:0]  FA = 5'd9;
    localparam logic [31:0] FD = 32'hDEAD_BEEF;

    logic          sys_clk = 1'b0;
    logic          RESET_N = 1'b1;
    logic [7:0]    src_data = 8'd0;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic          flush = 1'b0;
    logic          busy = 1'b0;
    logic [7:0]    stream_data;
    logic          stream_valid;
    logic [4:0]    reg_addr;
    logic [31:0]   reg_dta_in;
    logic          reg_wr_en;
    logic          init_done;
    logic [LW-1:0] level;
    logic [31:0]   byte_count;

    int          checks = 0;
    int          failures = 0;
    int          n_acc = 0;
    logic [7:0]  exp_q[$];
    logic [36:0] exp_reg[$];
    logic [31:0] exp_cnt = 32'd0;
    bit          track = 1'b0;
    logic        prev_busy = 1'b0;

    mpeg_stream_feeder #(
        .DEPTH(DEPTH), .INIT_ADDR0(A0), .INIT_DATA0(D0), .INIT_ADDR1(A1),
        .INIT_DATA1(D1), .FLUSH_ADDR(FA), .FLUSH_DATA(FD)
    ) dut (
        .sys_clk(sys_clk), .RESET_N(RESET_N), .src_data(src_data),
        .src_valid(src_valid), .src_ready(src_ready), .flush(flush), .busy(busy),
        .stream_data(stream_data), .stream_valid(stream_valid), .reg_addr(reg_addr),
        .reg_dta_in(reg_dta_in), .reg_wr_en(reg_wr_en), .init_done(init_done),
        .level(level), .byte_count(byte_count)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every DUT output event against the scoreboard queues
    always @(negedge sys_clk) begin
        logic [36:0] e;
        logic [7:0]  b;
        if (RESET_N) begin
            if (reg_wr_en) begin
                check("wr_with_valid", 64'(stream_valid), 64'(0));
                if (exp_reg.size() == 0) begin
                    check("reg_wr_unexpected", 64'(reg_wr_en), 64'(0));
                end else begin
                    e = exp_reg.pop_front();
                    check("reg_write", 64'({reg_addr, reg_dta_in}), 64'(e));
                end
            end
            if (stream_valid) begin
                if (prev_busy) check("valid_while_busy", 64'(stream_valid), 64'(0));
                if (exp_q.size() == 0) begin
                    check("stream_unexpected", 64'(stream_valid), 64'(0));
                end else begin
                    b = exp_q.pop_front();
                    check("stream_data", 64'(stream_data), 64'(b));
                end
                exp_cnt = exp_cnt + 32'd1;
                check("byte_count", 64'(byte_count), 64'(exp_cnt));
            end
            if (track) check("level", 64'(level), 64'(exp_q.size()));
        end
        prev_busy = busy;
    end

    // Offer one byte for a cycle; the model records it if the handshake completes
    task automatic offer(input bit v, input logic [7:0] d);
        bit acc;
        src_valid = v;
        src_data  = d;
        @(negedge sys_clk);
        acc = v && src_ready;
        @(posedge sys_clk);
        if (acc) begin
            exp_q.push_back(d);
            n_acc++;
        end
        #1;
        src_valid = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_src_ready", 64'(src_ready), 64'(0));
        check("rst_stream_valid", 64'(stream_valid), 64'(0));
        check("rst_stream_data", 64'(stream_data), 64'(0));
        check("rst_reg_wr_en", 64'(reg_wr_en), 64'(0));
        check("rst_reg_addr", 64'(reg_addr), 64'(0));
        check("rst_reg_dta_in", 64'(reg_dta_in), 64'(0));
        check("rst_init_done", 64'(init_done), 64'(0));
        check("rst_level", 64'(level), 64'(0));
        check("rst_byte_count", 64'(byte_count), 64'(0));
    endtask

    task automatic do_reset();
        RESET_N   = 1'b0;
        src_valid = 1'b0;
        flush     = 1'b0;
        busy      = 1'b0;
        track     = 1'b0;
        exp_q.delete();
        exp_reg.delete();
        exp_cnt   = 32'd0;
        #1;
        check_reset_vals();
        repeat (3) @(posedge sys_clk);
        #1;
        exp_reg.push_back({A0, D0});
        exp_reg.push_back({A1, D1});
        RESET_N = 1'b1;
        track   = 1'b1;
    endtask

    // Expect two back-to-back init writes; optionally pulse flush while in INIT1
    task automatic wait_init(input bit do_flush);
        int n = 0;
        check("init_done_pre", 64'(init_done), 64'(0));
        do begin
            @(negedge sys_clk);
            n++;
        end while (!reg_wr_en && n < 20);
        check("init_wr0_seen", 64'(reg_wr_en), 64'(1));
        check("init_done_low_wr0", 64'(init_done), 64'(0));
        if (do_flush) begin
            flush = 1'b1;
            exp_reg.push_back({FA, FD});
        end
        @(negedge sys_clk);
        flush = 1'b0;
        check("init_wr1_consecutive", 64'(reg_wr_en), 64'(1));
        check("init_done_high", 64'(init_done), 64'(1));
        @(negedge sys_clk);
        check("init_wr_single", 64'(reg_wr_en), 64'(0));
        repeat (4) @(negedge sys_clk);
        check("reg_q_drained", 64'(exp_reg.size()), 64'(0));
        check("init_done_stays", 64'(init_done), 64'(1));
        @(posedge sys_clk);
        #1;
    endtask

    task automatic drain(input int lim);
        int n = 0;
        while ((exp_q.size() != 0 || stream_valid) && n < lim) begin
            @(negedge sys_clk);
            n++;
        end
        check("drain_done", 64'(exp_q.size()), 64'(0));
        @(posedge sys_clk);
        #1;
        check("drain_level", 64'(level), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        bit acc;
        #2;
        // Reset and init sequence
        do_reset();
        wait_init(1'b0);

        // In-order streaming of 0x00..0x0F with latency check
        busy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            src_valid = 1'b1;
            src_data  = 8'(i);
            @(negedge sys_clk);
            acc = src_ready;
            check("stream_ready", 64'(src_ready), 64'(1));
            if (i == 1) check("lat_not_yet", 64'(stream_valid), 64'(0));
            if (i == 2) begin
                check("lat_valid", 64'(stream_valid), 64'(1));
                check("lat_first_data", 64'(stream_data), 64'(0));
            end
            @(posedge sys_clk);
            if (acc) exp_q.push_back(8'(i));
            #1;
        end
        src_valid = 1'b0;
        drain(40);
        check("stream_count", 64'(byte_count), 64'(16));

        // Back-pressure until full
        busy  = 1'b1;
        n_acc = 0;
        for (int i = 0; i < 20; i++) offer(1'b1, 8'($urandom));
        check("full_accepts", 64'(n_acc), 64'(16));
        check("full_level", 64'(level), 64'(DEPTH));
        check("full_ready", 64'(src_ready), 64'(0));
        busy = 1'b0;
        drain(60);

        // Busy toggling every 3 cycles with random traffic
        for (int c = 0; c < 90; c++) begin
            if (c % 3 == 0) busy = ~busy;
            offer(($urandom_range(0, 3) != 0), 8'($urandom));
        end
        busy = 1'b0;
        drain(80);

        // Flush with 8 bytes buffered
        busy = 1'b1;
        for (int i = 0; i < 8; i++) offer(1'b1, 8'($urandom));
        check("pre_flush_level", 64'(level), 64'(8));
        track = 1'b0;
        flush = 1'b1;
        exp_reg.push_back({FA, FD});
        @(posedge sys_clk);
        #1;
        flush = 1'b0;
        exp_q.delete();
        exp_cnt = 32'd0;
        @(posedge sys_clk);
        #1;
        check("flush_level", 64'(level), 64'(0));
        check("flush_byte_count", 64'(byte_count), 64'(0));
        check("flush_ready_blocked", 64'(src_ready), 64'(0));
        track = 1'b1;
        busy  = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        check("flush_wr_done", 64'(exp_reg.size()), 64'(0));
        for (int i = 0; i < 5; i++) offer(1'b1, 8'($urandom));
        drain(40);
        check("post_flush_count", 64'(byte_count), 64'(5));

        // Flush requested during INIT1
        do_reset();
        wait_init(1'b1);
        check("init_flush_level", 64'(level), 64'(0));
        for (int i = 0; i < 6; i++) offer(1'b1, 8'($urandom));
        drain(40);
        check("init_flush_count", 64'(byte_count), 64'(6));

        // Asynchronous reset while a byte is being issued
        for (int i = 0; i < 6; i++) offer(1'b1, 8'($urandom));
        check("pre_reset_valid", 64'(stream_valid), 64'(1));
        do_reset();
        wait_init(1'b0);
        for (int i = 0; i < 10; i++) offer(($urandom_range(0, 1) != 0), 8'($urandom));
        drain(40);
        check("final_reg_q", 64'(exp_reg.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
